flu_issue_scheduler: RTL and testbench



---
 rtl/flu_issue_scheduler.sv | 166 ++++++++++++++++
 tb/tb_flu_issue_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flu_issue_scheduler.sv
// Issue-side scheduler for the fixed-latency unit cluster (ALU/branch, CSR,
// pipelined multiplier, iterative divider). Dispatches one instruction per
// cycle and arbitrates the shared scoreboard writeback port with a reservation
// shift register so that no two results collide.
module flu_issue_scheduler #(
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned MULT_LAT      = 2,
    parameter int unsigned PERF_W        = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    input  logic [1:0]               issue_fu_i,
    input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
    output logic                     issue_ready_o,
    output logic                     alu_valid_o,
    output logic                     csr_valid_o,
    output logic                     mult_valid_o,
    output logic                     div_valid_o,
    input  logic                     csr_ready_i,
    input  logic                     div_done_i,
    output logic [1:0]               wb_sel_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic                     div_busy_o,
    output logic [PERF_W-1:0]        div_stall_cnt_o
);

    localparam logic [1:0] FuAlu = 2'd0;
    localparam logic [1:0] FuCsr = 2'd1;
    localparam logic [1:0] FuMul = 2'd2;
    localparam logic [1:0] FuDiv = 2'd3;

    localparam logic [1:0] WbNone  = 2'd0;
    localparam logic [1:0] WbIssue = 2'd1;
    localparam logic [1:0] WbMul   = 2'd2;
    localparam logic [1:0] WbDiv   = 2'd3;

    localparam logic [PERF_W-1:0] CntOne = {{(PERF_W-1){1'b0}}, 1'b1};

    typedef enum logic {StIdle, StBusy} div_state_e;

    // r_q[0] set: a multiplier result owns the writeback port this cycle.
    logic [MULT_LAT-1:0]                     r_q, r_d;
    logic [MULT_LAT-1:0][TRANS_ID_BITS-1:0]  tid_q, tid_d;
    logic [TRANS_ID_BITS-1:0]                div_tid_q, div_tid_d;
    div_state_e                              state_q, state_d;
    logic [PERF_W-1:0]                       stall_cnt_q, stall_cnt_d;

    logic accept;
    logic div_wb;
    logic mul_wb;
    logic iss_wb;

    // Readiness for the offered unit; never looks at issue_valid_i.
    always_comb begin
        issue_ready_o = 1'b0;
        if (!rst_i && !flush_i && (state_q == StIdle)) begin
            unique case (issue_fu_i)
                FuAlu:   issue_ready_o = !r_q[0];
                FuCsr:   issue_ready_o = !r_q[0] && csr_ready_i;
                FuMul:   issue_ready_o = 1'b1;
                FuDiv:   issue_ready_o = (r_q == '0);
                default: issue_ready_o = 1'b0;
            endcase
        end
    end

    assign accept       = issue_valid_i && issue_ready_o;
    assign alu_valid_o  = accept && (issue_fu_i == FuAlu);
    assign csr_valid_o  = accept && (issue_fu_i == FuCsr);
    assign mult_valid_o = accept && (issue_fu_i == FuMul);
    assign div_valid_o  = accept && (issue_fu_i == FuDiv);

    assign div_busy_o      = (state_q == StBusy);
    assign div_stall_cnt_o = stall_cnt_q;

    // Reservation shift register and its parallel trans-id pipe.
    always_comb begin
        r_d   = r_q >> 1;
        tid_d = tid_q >> TRANS_ID_BITS;
        if (mult_valid_o) begin
            r_d[MULT_LAT-1]   = 1'b1;
            tid_d[MULT_LAT-1] = issue_trans_id_i;
        end
        if (flush_i) begin
            r_d   = '0;
            tid_d = '0;
        end
    end

    // Divider FSM next state; done while idle is ignored.
    always_comb begin
        state_d   = state_q;
        div_tid_d = div_tid_q;
        unique case (state_q)
            StIdle: begin
                if (div_valid_o) begin
                    state_d   = StBusy;
                    div_tid_d = issue_trans_id_i;
                end
            end
            StBusy: begin
                if (div_done_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d   = StIdle;
            div_tid_d = '0;
        end
    end

    // Saturating count of cycles where issue is held off by the divider; survives flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == StBusy) && issue_valid_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    // Writeback owner select; divider outranks multiplier outranks issue.
    always_comb begin
        wb_sel_o      = WbNone;
        wb_trans_id_o = '0;
        if (div_wb) begin
            wb_sel_o      = WbDiv;
            wb_trans_id_o = div_tid_q;
        end else if (mul_wb) begin
            wb_sel_o      = WbMul;
            wb_trans_id_o = tid_q[0];
        end else if (iss_wb) begin
            wb_sel_o      = WbIssue;
            wb_trans_id_o = issue_trans_id_i;
        end
    end

    assign div_wb = (state_q == StBusy) && div_done_i;
    assign mul_wb = r_q[0];
    assign iss_wb = alu_valid_o || csr_valid_o;

    // State registers; reset abandons any divide in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q         <= '0;
            tid_q       <= '0;
            div_tid_q   <= '0;
            state_q     <= StIdle;
            stall_cnt_q <= '0;
        end else begin
            r_q         <= r_d;
            tid_q       <= tid_d;
            div_tid_q   <= div_tid_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifndef SYNTHESIS
    wb_single_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0({div_wb, mul_wb, iss_wb}));
`endif

endmodule

// File: tb/tb_flu_issue_scheduler.sv
// Table-driven bench for flu_issue_scheduler with a scoreboard for multiplier
// writebacks and hand-written reset sequences.
module tb_flu_issue_scheduler;

    localparam int unsigned TIDW = 3;
    localparam int unsigned LAT  = 2;
    localparam int unsigned PW   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            ivalid;
    logic [1:0]      ifu;
    logic [TIDW-1:0] itid;
    logic            iready;
    logic            alu_v, csr_v, mul_v, div_v;
    logic            csr_rdy;
    logic            div_done;
    logic [1:0]      wb_sel;
    logic [TIDW-1:0] wb_tid;
    logic            busy;
    logic [PW-1:0]   cnt;

    flu_issue_scheduler #(
        .TRANS_ID_BITS(TIDW),
        .MULT_LAT     (LAT),
        .PERF_W       (PW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .issue_valid_i   (ivalid),
        .issue_fu_i      (ifu),
        .issue_trans_id_i(itid),
        .issue_ready_o   (iready),
        .alu_valid_o     (alu_v),
        .csr_valid_o     (csr_v),
        .mult_valid_o    (mul_v),
        .div_valid_o     (div_v),
        .csr_ready_i     (csr_rdy),
        .div_done_i      (div_done),
        .wb_sel_o        (wb_sel),
        .wb_trans_id_o   (wb_tid),
        .div_busy_o      (busy),
        .div_stall_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            v;
        logic [1:0]      fu;
        logic [TIDW-1:0] id;
        logic            fl;
        logic            cr;
        logic            dd;
        logic            e_rdy;
        logic [3:0]      e_disp;  // {div, mul, csr, alu}
        logic [1:0]      e_sel;
        logic [TIDW-1:0] e_tid;   // checked only when e_sel != 2
        logic            e_busy;
        logic [PW-1:0]   e_cnt;
    } vec_t;

    typedef struct {
        int              due;
        logic [TIDW-1:0] id;
    } sb_t;

    vec_t vt[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    function automatic vec_t mk(input logic v, input logic [1:0] fu, input logic [TIDW-1:0] id,
                                input logic fl, input logic cr, input logic dd,
                                input logic e_rdy, input logic [3:0] e_disp,
                                input logic [1:0] e_sel, input logic [TIDW-1:0] e_tid,
                                input logic e_busy, input logic [PW-1:0] e_cnt);
        vec_t t;
        t.v = v; t.fu = fu; t.id = id; t.fl = fl; t.cr = cr; t.dd = dd;
        t.e_rdy = e_rdy; t.e_disp = e_disp; t.e_sel = e_sel; t.e_tid = e_tid;
        t.e_busy = e_busy; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] fu, input logic [TIDW-1:0] id,
                         input logic fl, input logic cr, input logic dd);
        ivalid = v; ifu = fu; itid = id; flush = fl; csr_rdy = cr; div_done = dd;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, {31'd0, iready}, 32'd0);
        chk({nm, "_disp"}, {28'd0, div_v, mul_v, csr_v, alu_v}, 32'd0);
        chk({nm, "_wb_sel"}, {30'd0, wb_sel}, 32'd0);
        chk({nm, "_wb_tid"}, {29'd0, wb_tid}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_cnt"}, {16'd0, cnt}, 32'd0);
    endtask

    // One clock cycle: drive after the edge, check at the falling edge.
    task automatic run_vec(input vec_t t);
        sb_t e;
        @(posedge clk);
        #1;
        drive(t.v, t.fu, t.id, t.fl, t.cr, t.dd);
        @(negedge clk);
        chk("ready", {31'd0, iready}, {31'd0, t.e_rdy});
        chk("dispatch", {28'd0, div_v, mul_v, csr_v, alu_v}, {28'd0, t.e_disp});
        chk("wb_sel", {30'd0, wb_sel}, {30'd0, t.e_sel});
        if (t.e_sel != 2'd2) chk("wb_tid", {29'd0, wb_tid}, {29'd0, t.e_tid});
        chk("div_busy", {31'd0, busy}, {31'd0, t.e_busy});
        chk("stall_cnt", {16'd0, cnt}, {16'd0, t.e_cnt});
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("sb_mul_sel", {30'd0, wb_sel}, 32'd2);
            chk("sb_mul_tid", {29'd0, wb_tid}, {29'd0, e.id});
        end
        if (t.e_disp[2]) begin
            e.due = cyc + LAT;
            e.id  = t.id;
            sb.push_back(e);
        end
        if (t.fl) sb.delete();
        cyc++;
    endtask

    initial begin
        // MUL 5, ALU 6 accepted behind it, ALU 7 held off by the MUL writeback.
        vt.push_back(mk(1, 2, 5, 0, 1, 0, 1, 4'b0100, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 6, 0, 1, 0, 1, 4'b0001, 1, 6, 0, 0));
        vt.push_back(mk(1, 0, 7, 0, 1, 0, 0, 4'b0000, 2, 0, 0, 0));
        vt.push_back(mk(1, 0, 7, 0, 1, 0, 1, 4'b0001, 1, 7, 0, 0));
        // Back-to-back MUL 1, 2, 3.
        vt.push_back(mk(1, 2, 1, 0, 1, 0, 1, 4'b0100, 0, 0, 0, 0));
        vt.push_back(mk(1, 2, 2, 0, 1, 0, 1, 4'b0100, 0, 0, 0, 0));
        vt.push_back(mk(1, 2, 3, 0, 1, 0, 1, 4'b0100, 2, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'b0000, 2, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'b0000, 2, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 0));
        // MUL then DIV waits for the multiplier to drain, then stalls issue.
        vt.push_back(mk(1, 2, 4, 0, 1, 0, 1, 4'b0100, 0, 0, 0, 0));
        vt.push_back(mk(1, 3, 5, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0));
        vt.push_back(mk(1, 3, 5, 0, 1, 0, 0, 4'b0000, 2, 0, 0, 0));
        vt.push_back(mk(1, 3, 5, 0, 1, 0, 1, 4'b1000, 0, 0, 0, 0));
        for (int k = 0; k < 6; k++)
            vt.push_back(mk(1, 3, 6, 0, 1, 0, 0, 4'b0000, 0, 0, 1, PW'(k)));
        vt.push_back(mk(1, 3, 6, 0, 1, 1, 0, 4'b0000, 3, 5, 1, 6));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 7));
        // Done while idle is ignored.
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4'b0000, 0, 0, 0, 7));
        // CSR waits for csr_ready.
        vt.push_back(mk(1, 1, 2, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 7));
        vt.push_back(mk(1, 1, 2, 0, 1, 0, 1, 4'b0010, 1, 2, 0, 7));
        // Flush drops a pending MUL result.
        vt.push_back(mk(1, 2, 6, 0, 1, 0, 1, 4'b0100, 0, 0, 0, 7));
        vt.push_back(mk(1, 0, 1, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 7));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 7));
        // Flush while the divider is busy returns to idle.
        vt.push_back(mk(1, 3, 3, 0, 1, 0, 1, 4'b1000, 0, 0, 0, 7));
        vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 1, 7));
        vt.push_back(mk(1, 0, 4, 0, 1, 0, 1, 4'b0001, 1, 4, 0, 7));
        // Flush in the MUL writeback cycle still shows the MUL owner.
        vt.push_back(mk(1, 2, 5, 0, 1, 0, 1, 4'b0100, 0, 0, 0, 7));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 7));
        vt.push_back(mk(1, 0, 2, 1, 1, 0, 0, 4'b0000, 2, 0, 0, 7));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 7));

        // Reset: an ALU is offered, yet everything must read zero.
        rst = 1'b1;
        drive(1, 0, 3, 0, 1, 0);
        #3;
        chk_all_zero("por");
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) run_vec(vt[i]);

        // Async reset in the middle of a divide.
        run_vec(mk(1, 3, 1, 0, 1, 0, 1, 4'b1000, 0, 0, 0, 7));
        @(posedge clk);
        cyc++;
        #1;
        drive(1, 2, 3, 0, 1, 0);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_busy");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        // Async reset with a MUL result still in flight.
        run_vec(mk(1, 2, 7, 0, 1, 0, 1, 4'b0100, 0, 0, 0, 0));
        @(posedge clk);
        cyc++;
        #1;
        drive(0, 0, 0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mul");
        sb.delete();
        @(posedge clk);
        cyc++;
        #1;
        chk("rst_mul_due_sel", {30'd0, wb_sel}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First cycle after release: idle, ALU accepted.
        run_vec(mk(1, 0, 5, 0, 1, 0, 1, 4'b0001, 1, 5, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
